// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmit and receive paths
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   UART_DATA_BITS            = 8;
  localparam int   UART_DEFAULT_CLKS_PER_BIT = 10;
  localparam logic UART_IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte handshake between the producer and the UART transmitter
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_start;
  logic                      tx_ready;
  logic                      tx_busy;
  logic                      tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_ready,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_ready,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - bit-period counter, ticks on the last clock of each bit
module tx_bit_timer #(
  parameter  int CLKS_PER_BIT = 10,
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          bit_tick
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign bit_tick = enable && (count_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter: FSM, shift register and bit index
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   tx,
  output logic                serial_out
);

  localparam int         CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 timer_clear;
  logic                 bit_tick;
  logic [CW-1:0]        bit_count;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q != IDLE),
    .clear    (timer_clear),
    .count    (bit_count),
    .bit_tick (bit_tick)
  );

  // serial_d is the level for the cycle after this edge, so the line is registered.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    serial_d    = serial_q;
    done_d      = 1'b0;
    timer_clear = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d = UART_IDLE_LEVEL;
        if (tx.tx_start) begin
          shift_d     = tx.tx_data;
          timer_clear = 1'b1;
          state_d     = START;
          serial_d    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d  = STOP;
            serial_d = UART_IDLE_LEVEL;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= UART_IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE) begin
      assert (bit_count == '0);
    end
  end

  assign serial_out  = serial_q;
  assign tx.tx_ready = (state_q == IDLE);
  assign tx.tx_busy  = (state_q != IDLE);
  assign tx.tx_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter with an in-bench serial receiver
module tb_uart_transmitter;

  localparam int N     = 10;
  localparam int FRAME = 10 * N;

  logic clk = 1'b0;
  logic rst;
  logic serial_out;

  always #5 clk = ~clk;

  uart_transmitter_if tx_if ();

  uart_transmitter #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (tx_if),
    .serial_out (serial_out)
  );

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Receiver/scoreboard: expected line level at frame cycle j follows from the 10-slot 8N1 layout.
  bit         armed     = 0;
  bit         after_rst = 0;
  bit         in_frame  = 0;
  int         j;
  int         slot;
  logic       lvl;
  logic [7:0] rx;
  exp_t       cur;
  logic [3:0] vec;

  always @(negedge clk) begin
    vec = {serial_out, tx_if.tx_busy, tx_if.tx_ready, tx_if.tx_done};
    if (rst === 1'b1) begin
      armed     = 1;
      after_rst = 1;
      in_frame  = 0;
    end else if (armed) begin
      if (after_rst) begin
        check("reset_state", vec, 4'b1010);
        after_rst = 0;
      end else if (in_frame) begin
        j++;
        if (j <= FRAME) begin
          slot = (j - 1) / N;
          lvl  = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : cur.data[slot-1];
          check("frame_cycle", vec, {lvl, 3'b100});
          if ((j - 1) % N == N / 2 && slot >= 1 && slot <= 8) rx[slot-1] = serial_out;
        end else begin
          check("frame_end_done", vec, 4'b1011);
          check("loopback_byte", rx, cur.data);
          in_frame = 0;
        end
      end else if (serial_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", exp_q.size(), 1);
        end else begin
          cur = exp_q.pop_front();
          check("start_latency", cyc, cur.acc);
          check("frame_cycle", vec, 4'b0100);
          j        = 1;
          rx       = '0;
          in_frame = 1;
        end
      end else begin
        check("idle_state", vec, 4'b1010);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (tx_if.tx_ready !== 1'b1 && t < 2 * FRAME) begin
      tick();
      t++;
    end
    if (t >= 2 * FRAME) check("ready_timeout", tx_if.tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    wait_ready();
    tx_if.tx_data  = b;
    tx_if.tx_start = 1'b1;
    tick();
    acc = cyc;
    exp_q.push_back('{data: b, acc: cyc});
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (tx_if.tx_busy !== 1'b0 && t < 2 * FRAME) begin
      tick();
      t++;
    end
    if (t >= 2 * FRAME) check("idle_timeout", tx_if.tx_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d frames pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int         a1;
    int         a2;
    logic [7:0] lb[4];

    lb = '{8'h00, 8'hFF, 8'h81, 8'h7E};
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = 8'h00;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(50);

    send(8'hA5, a1);
    wait_idle();
    tick(3);

    // Busy-ignore: a second request 40 cycles into the frame must be dropped.
    send(8'h3C, a1);
    tick(39);
    tx_if.tx_data  = 8'hFF;
    tx_if.tx_start = 1'b1;
    tick();
    tx_if.tx_start = 1'b0;
    wait_idle();
    tick(FRAME / 2);

    // Back-to-back with tx_start held high; data changes after accept.
    wait_ready();
    tx_if.tx_data  = 8'h00;
    tx_if.tx_start = 1'b1;
    tick();
    a1 = cyc;
    exp_q.push_back('{data: 8'h00, acc: cyc});
    tx_if.tx_data = 8'hFF;
    wait_ready();
    tick();
    a2 = cyc;
    exp_q.push_back('{data: 8'hFF, acc: cyc});
    tx_if.tx_start = 1'b0;
    check("b2b_gap", a2 - a1, FRAME + 1);
    wait_idle();
    tick(3);

    // Reset lands on the edge closing cycle 35 of the frame.
    send(8'h55, a1);
    tick(34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(5);
    check("rst_drops_pending", exp_q.size(), 0);
    send(8'hC3, a1);
    wait_idle();
    tick(2);

    foreach (lb[k]) begin
      send(lb[k], a1);
      wait_idle();
      tick(1);
    end

    for (int r = 0; r < 8; r++) begin
      int gap;
      gap = $urandom_range(0, 12);
      for (int g = 0; g < gap; g++) begin
        tx_if.tx_data = 8'($urandom);
        tick();
      end
      send(8'($urandom), a1);
    end
    wait_idle();
    tick(5);
    check("pending_frames", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
